// File: rtl/rdi_sb_pkg.sv
// Shared sideband encodings and arbiter state type for the RDI bring-up TX/RX paths and the sideband TX arbiter.
package rdi_sb_pkg;

   localparam int SB_MSG_W = 4;

   localparam logic [SB_MSG_W-1:0] SB_MSG_NONE      = 4'd0;
   localparam logic [SB_MSG_W-1:0] ACTIVE_REQ       = 4'd1;
   localparam logic [SB_MSG_W-1:0] PM_L1_REQ        = 4'd2;
   localparam logic [SB_MSG_W-1:0] PM_L2_REQ        = 4'd3;
   localparam logic [SB_MSG_W-1:0] LINKERROR_REQ    = 4'd4;
   localparam logic [SB_MSG_W-1:0] RETRAIN_REQ      = 4'd5;
   localparam logic [SB_MSG_W-1:0] LINKRESET_REQ    = 4'd6;
   localparam logic [SB_MSG_W-1:0] DISABLE_REQ      = 4'd7;
   localparam logic [SB_MSG_W-1:0] ACTIVE_RSP       = 4'd8;
   localparam logic [SB_MSG_W-1:0] PM_L1_RSP        = 4'd9;
   localparam logic [SB_MSG_W-1:0] PM_L2_RSP        = 4'd10;
   localparam logic [SB_MSG_W-1:0] LINKERROR_RSP    = 4'd11;
   localparam logic [SB_MSG_W-1:0] RETRAIN_RSP      = 4'd12;
   localparam logic [SB_MSG_W-1:0] LINKRESET_RSP    = 4'd13;
   localparam logic [SB_MSG_W-1:0] PM_NAK_MSG       = 4'd14;
   localparam logic [SB_MSG_W-1:0] DISABLE_RSP      = 4'd15;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_ISSUE     = 2'd1,
      ST_WAIT_DONE = 2'd2
   } sb_arb_state_e;

   typedef enum logic {
      GNT_TX = 1'b0,
      GNT_RX = 1'b1
   } sb_gnt_e;

endpackage

// File: rtl/rdi_sb_slot.sv
// One-deep request holding slot; zero messages are ignored and a strobe into a full slot is dropped and flagged.
// A clear and a new strobe on the same edge leave the slot holding the new message.
module rdi_sb_slot
   import rdi_sb_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                i_vld,
   input  logic [SB_MSG_W-1:0] i_msg,
   input  logic                i_clr,
   output logic                o_full,
   output logic                o_full_d,
   output logic [SB_MSG_W-1:0] o_msg,
   output logic                o_ovf
);

   logic                full_q, full_d;
   logic [SB_MSG_W-1:0] msg_q, msg_d;
   logic                strobe;
   logic                capture;

   always_comb begin
      strobe  = i_vld && (i_msg != SB_MSG_NONE);
      capture = strobe && (!full_q || i_clr);
      o_ovf   = strobe && full_q && !i_clr;
      full_d  = full_q;
      msg_d   = msg_q;
      if (capture) begin
         full_d = 1'b1;
         msg_d  = i_msg;
      end else if (i_clr) begin
         full_d = 1'b0;
         msg_d  = SB_MSG_NONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         full_q <= 1'b0;
         msg_q  <= SB_MSG_NONE;
      end else begin
         full_q <= full_d;
         msg_q  <= msg_d;
      end
   end

   assign o_full   = full_q;
   assign o_full_d = full_d;
   assign o_msg    = msg_q;

endmodule

// File: rtl/rdi_sb_tx_arbiter.sv
// Arbitrates bring-up TX and RX sideband messages onto one channel; strobe at k -> o_sb_msg_valid at k+2, held in IDLE while i_sb_busy.
// RDI_SB_ARB_TIMEOUT_EN adds a WAIT_DONE abort after TIMEOUT_CYCLES and the o_timeout pulse.
module rdi_sb_tx_arbiter
   import rdi_sb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                lclk,
   input  logic                sys_rst,
   input  logic [SB_MSG_W-1:0] i_tx_sb_message,
   input  logic                i_tx_msg_valid,
   input  logic [SB_MSG_W-1:0] i_rx_sb_message,
   input  logic                i_rx_msg_valid,
   input  logic                i_sb_busy,
   input  logic                i_sb_done,
   output logic [SB_MSG_W-1:0] o_sb_message,
   output logic                o_sb_msg_valid,
   output logic                o_tx_done_send_message,
   output logic                o_rx_done_send_message,
   output logic                o_rx_busy_from_TX,
   output logic                o_overflow
`ifdef RDI_SB_ARB_TIMEOUT_EN
   ,
   output logic                o_timeout
`endif
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 1..65535");
   end

   sb_arb_state_e       state_q, state_d;
   sb_gnt_e             gnt_q, gnt_d;
   sb_gnt_e             last_q, last_d;
   logic [SB_MSG_W-1:0] msg_q, msg_d;
   logic                vld_q, vld_d;
   logic                tx_done_q, tx_done_d;
   logic                rx_done_q, rx_done_d;
   logic                busy_q, busy_d;
   logic                ovf_q, ovf_d;
   logic                clr_tx, clr_rx;
   logic                tx_full, tx_full_d, tx_ovf;
   logic                rx_full, rx_full_d, rx_ovf;
   logic [SB_MSG_W-1:0] tx_msg, rx_msg;
   logic                finish;
`ifdef RDI_SB_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0]         cnt_q, cnt_d;
   logic                timeout_q, timeout_d;
`endif

   rdi_sb_slot u_tx_slot (
      .clk      (lclk),
      .rst      (sys_rst),
      .i_vld    (i_tx_msg_valid),
      .i_msg    (i_tx_sb_message),
      .i_clr    (clr_tx),
      .o_full   (tx_full),
      .o_full_d (tx_full_d),
      .o_msg    (tx_msg),
      .o_ovf    (tx_ovf)
   );

   rdi_sb_slot u_rx_slot (
      .clk      (lclk),
      .rst      (sys_rst),
      .i_vld    (i_rx_msg_valid),
      .i_msg    (i_rx_sb_message),
      .i_clr    (clr_rx),
      .o_full   (rx_full),
      .o_full_d (rx_full_d),
      .o_msg    (rx_msg),
      .o_ovf    (rx_ovf)
   );

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      last_d    = last_q;
      msg_d     = msg_q;
      vld_d     = 1'b0;
      tx_done_d = 1'b0;
      rx_done_d = 1'b0;
      clr_tx    = 1'b0;
      clr_rx    = 1'b0;
      finish    = 1'b0;
`ifdef RDI_SB_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if ((tx_full || rx_full) && !i_sb_busy) begin
               // On a tie the requester that lost the previous grant wins.
               gnt_d   = (rx_full && (!tx_full || last_q == GNT_TX)) ? GNT_RX : GNT_TX;
               last_d  = gnt_d;
               msg_d   = (gnt_d == GNT_RX) ? rx_msg : tx_msg;
               vld_d   = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT_DONE;
`ifdef RDI_SB_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         ST_WAIT_DONE: begin
            if (i_sb_done) begin
               finish    = 1'b1;
               tx_done_d = (gnt_q == GNT_TX);
               rx_done_d = (gnt_q == GNT_RX);
            end
`ifdef RDI_SB_ARB_TIMEOUT_EN
            else if (cnt_q == TO_LAST) begin
               finish    = 1'b1;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
            if (finish) begin
               clr_tx  = (gnt_q == GNT_TX);
               clr_rx  = (gnt_q == GNT_RX);
               msg_d   = SB_MSG_NONE;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy_d = tx_full_d || (gnt_d == GNT_TX && state_d != ST_IDLE);
   assign ovf_d  = tx_ovf || rx_ovf;

   always_ff @(posedge lclk) begin
      if (sys_rst) begin
         state_q   <= ST_IDLE;
         gnt_q     <= GNT_TX;
         last_q    <= GNT_TX;
         msg_q     <= SB_MSG_NONE;
         vld_q     <= 1'b0;
         tx_done_q <= 1'b0;
         rx_done_q <= 1'b0;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
`ifdef RDI_SB_ARB_TIMEOUT_EN
         cnt_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         last_q    <= last_d;
         msg_q     <= msg_d;
         vld_q     <= vld_d;
         tx_done_q <= tx_done_d;
         rx_done_q <= rx_done_d;
         busy_q    <= busy_d;
         ovf_q     <= ovf_d;
`ifdef RDI_SB_ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign o_sb_message           = msg_q;
   assign o_sb_msg_valid         = vld_q;
   assign o_tx_done_send_message = tx_done_q;
   assign o_rx_done_send_message = rx_done_q;
   assign o_rx_busy_from_TX      = busy_q;
   assign o_overflow             = ovf_q;
`ifdef RDI_SB_ARB_TIMEOUT_EN
   assign o_timeout              = timeout_q;
`endif

endmodule

// File: doc/rdi_sb_tx_arbiter.md
RDI_SB_TX_ARBITER -- requirements
Module: rdi_sb_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1023, number of cycles waited for sideband completion before abort (16-bit range, 1..65535).
REQ-002 SHALL have port lclk  input  1  local clock; all logic on its rising edge.
REQ-003 SHALL have port sys_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port i_tx_sb_message  input  4  request message from bring-up TX path (ACTIVE_REQ..DISABLE_REQ encodings).
REQ-005 SHALL have port i_tx_msg_valid  input  1  one-cycle strobe qualifying i_tx_sb_message.
REQ-006 SHALL have port i_rx_sb_message  input  4  response message from bring-up RX path (ACTIVE_RSP..DISABLE_RSP, PM_NAK_MSG).
REQ-007 SHALL have port i_rx_msg_valid  input  1  one-cycle strobe qualifying i_rx_sb_message.
REQ-008 SHALL have port i_sb_busy  input  1  sideband TX channel cannot accept a message this cycle.
REQ-009 SHALL have port i_sb_done  input  1  one-cycle pulse, sideband finished serialising current message.
REQ-010 SHALL have port o_sb_message  output  4  message to sideband TX.
REQ-011 SHALL have port o_sb_msg_valid  output  1  one-cycle strobe qualifying o_sb_message.
REQ-012 SHALL have port o_tx_done_send_message  output  1  one-cycle pulse, TX-path message sent.
REQ-013 SHALL have port o_rx_done_send_message  output  1  one-cycle pulse, RX-path message sent.
REQ-014 SHALL have port o_rx_busy_from_TX  output  1  high while a TX-path message is held or in flight.
REQ-015 SHALL have port o_overflow  output  1  one-cycle pulse, a strobe arrived while its slot was full.

Function
REQ-016 SHALL hold one 1-deep slot per requester; valid strobe with message != 0 and slot empty captures message at that edge.
REQ-017 SHALL ignore strobes carrying message 0 (no capture, no overflow).
REQ-018 SHALL drop a strobe arriving while its slot is full, keep the held message, pulse o_overflow next cycle.
REQ-019 SHALL implement FSM IDLE, ISSUE, WAIT_DONE, all outputs registered.
REQ-020 SHALL in IDLE with any slot full and i_sb_busy low grant one slot and go to ISSUE; i_sb_busy high holds IDLE.
REQ-021 SHALL grant RX slot when only it is full, TX slot when only it is full; when both full, grant the requester not granted last (last-grant flag resets to TX, so RX wins first tie).
REQ-022 SHALL in ISSUE drive o_sb_msg_valid high for exactly one cycle with granted message, then go to WAIT_DONE; o_sb_message holds value until leaving WAIT_DONE, else 0.
REQ-023 SHALL in WAIT_DONE on i_sb_done clear granted slot, pulse owner's done output one cycle, return to IDLE.
REQ-024 SHALL ignore i_sb_done in IDLE and ISSUE.
REQ-025 SHALL give latency: strobe at cycle k, channel idle -> o_sb_msg_valid high in cycle k+2.
REQ-026 SHALL allow a slot cleared by i_sb_done to capture a new strobe on the same edge (capture wins).
REQ-027 SHALL drive o_rx_busy_from_TX = TX slot full OR (TX granted and not IDLE).

Reset
REQ-028 SHALL on sys_rst high at an edge clear both slots, FSM to IDLE, last-grant to TX, counter to 0, all outputs to 0, regardless of state; in-flight message abandoned, no done pulse.

Configuration
REQ-029 SHALL with RDI_SB_ARB_TIMEOUT_EN defined count cycles in WAIT_DONE; at TIMEOUT_CYCLES without i_sb_done, clear granted slot, return to IDLE, no done pulse, pulse o_timeout (extra output, 1 bit).
REQ-030 SHALL without RDI_SB_ARB_TIMEOUT_EN wait in WAIT_DONE indefinitely; no counter, no o_timeout port.

Structure
REQ-031 SHALL place 4-bit message encodings and FSM state encoding in shared package rdi_sb_pkg, reused by bring-up TX/RX.
REQ-032 SHALL implement the slot as sub-module rdi_sb_slot, instantiated twice.

Verification
REQ-033 SHALL cover: TX strobe ACTIVE_REQ(1) at cycle 5, idle -> o_sb_message=1 valid cycle 7, o_rx_busy_from_TX high cycles 6..done; i_sb_done cycle 12 -> o_tx_done_send_message cycle 13.
REQ-034 SHALL cover: TX 6 and RX 14 strobed same cycle -> 14 sent first, 6 after its done; next tie -> TX first.
REQ-035 SHALL cover: second TX strobe 7 while slot holds 6 -> o_overflow one pulse, 6 still sent, 7 never sent.
REQ-036 SHALL cover: i_sb_busy high 10 cycles with slot full -> no o_sb_msg_valid until 2 cycles... precisely first cycle after busy falls plus one.
REQ-037 SHALL cover: sys_rst in WAIT_DONE -> all outputs 0 next cycle, late i_sb_done ignored; with macro, TIMEOUT_CYCLES=8 and no done -> o_timeout after 8 WAIT_DONE cycles, slot empty.
